// File: rtl/adc_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// adc_trace_buffer_if
// ADC output bus as seen by the trace buffer: one beat qualifier, the packed
// lane data and the external trigger that travels with each beat.
//   in_valid  beat qualifier
//   in_data   N_TI lanes of N_ADC bits, lane i at [i*N_ADC +: N_ADC]
//   ext_trig  external trigger, only meaningful on in_valid beats
// master = ADC side (drives), slave = trace buffer (samples).
// ---------------------------------------------------------------------------
interface adc_trace_buffer_if #(
    parameter int N_TI  = 16,
    parameter int N_ADC = 8
);
    logic                    in_valid;
    logic [N_TI*N_ADC-1:0]   in_data;
    logic                    ext_trig;

    modport master (output in_valid, output in_data, output ext_trig);
    modport slave  (input  in_valid, input  in_data, input  ext_trig);
endinterface

// File: rtl/adc_trace_buffer.sv
// ---------------------------------------------------------------------------
// adc_trace_buffer
// Circular capture memory for the time-interleaved ADC. After arm, beats are
// written to a DEPTH-word ring; pretrig words are kept ahead of the trigger
// and DEPTH-1-pretrig words after it, so a finished capture fills the ring
// exactly once around the trigger word.
// Ports:
//   clk, rstb     clock, synchronous active-low reset
//   adc_if        ADC bus (in_valid, in_data, ext_trig), slave side
//   arm_i         pulse: start/restart a capture (latches pretrig_i)
//   abort_i       return to IDLE, memory retained; wins over arm_i
//   trig_mode_i   0/3 immediate, 1 ext_trig, 2 any lane > thresh_i (signed)
//   thresh_i      signed level threshold
//   pretrig_i     words kept before the trigger word
//   rd_addr_i     logical read index, 0 = oldest captured word
//   rd_data_o     registered read data, one cycle after rd_addr_i
//   state_o       IDLE=0 FILL=1 WAIT_TRIG=2 POST=3 DONE=4
//   done_o        capture complete, buffer stable
//   trig_addr_o   physical address of the trigger word
// ---------------------------------------------------------------------------
module adc_trace_buffer #(
    parameter int N_TI   = 16,
    parameter int N_ADC  = 8,
    parameter int N_ADDR = 10
) (
    input  logic                        clk,
    input  logic                        rstb,
    adc_trace_buffer_if.slave           adc_if,
    input  logic                        arm_i,
    input  logic                        abort_i,
    input  logic [1:0]                  trig_mode_i,
    input  logic signed [N_ADC-1:0]     thresh_i,
    input  logic [N_ADDR-1:0]           pretrig_i,
    input  logic [N_ADDR-1:0]           rd_addr_i,
    output logic [N_TI*N_ADC-1:0]       rd_data_o,
    output logic [2:0]                  state_o,
    output logic                        done_o,
    output logic [N_ADDR-1:0]           trig_addr_o
);
    localparam int DEPTH = 2**N_ADDR;
    localparam int W     = N_TI*N_ADC;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } state_e;

    state_e              state_q;
    logic                done_q;
    logic [N_ADDR-1:0]   trig_addr_q;
    logic [N_ADDR-1:0]   wr_ptr_q;
    logic [N_ADDR-1:0]   cnt_q;
    logic [N_ADDR-1:0]   pretrig_q;
    logic [W-1:0]        rd_data_q;
    logic [W-1:0]        mem [DEPTH];

    logic [N_ADDR-1:0]   cnt_d;
    logic [N_ADDR-1:0]   post_len;
    logic [N_ADDR-1:0]   rd_idx;
    logic                capturing;
    logic                wr_en;
    logic                level_hit;
    logic                trig_hit;

    assign cnt_d     = cnt_q + 1'b1;
    // DEPTH-1-pretrig in N_ADDR bits is simply the bitwise complement.
    assign post_len  = ~pretrig_q;
    assign rd_idx    = trig_addr_q - pretrig_q + rd_addr_i;
    assign capturing = (state_q == FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
    // arm/abort cycles never write: the capture they end or restart must not
    // take one more beat at the old write pointer.
    assign wr_en     = rstb && capturing && adc_if.in_valid && !arm_i && !abort_i;

    // NOTE: always_comb outputs get a default first so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        level_hit = 1'b0;
        for (int i = 0; i < N_TI; i++) begin
            if ($signed(adc_if.in_data[i*N_ADC +: N_ADC]) > thresh_i) begin
                level_hit = 1'b1;
            end
        end
    end

    always_comb begin
        case (trig_mode_i)
            2'd1:    trig_hit = adc_if.ext_trig;
            2'd2:    trig_hit = level_hit;
            default: trig_hit = 1'b1;   // immediate; reserved code 3 behaves the same
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            trig_addr_q <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pretrig_q   <= '0;
        end else if (abort_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else if (arm_i) begin
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            pretrig_q <= pretrig_i;
            state_q   <= (pretrig_i != '0) ? FILL : WAIT_TRIG;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case (state_q)
                FILL: begin
                    if (adc_if.in_valid) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == pretrig_q) begin
                            state_q <= WAIT_TRIG;
                        end
                    end
                end
                WAIT_TRIG: begin
                    if (adc_if.in_valid && trig_hit) begin
                        trig_addr_q <= wr_ptr_q;
                        cnt_q       <= '0;
                        if (post_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= POST;
                        end
                    end
                end
                POST: begin
                    if (adc_if.in_valid) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == post_len) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: ;  // IDLE and DONE hold until arm/abort
            endcase
        end
    end

    // NOTE: the sample memory has no reset; clearing it would need a
    // per-word sweep and the contents are only meaningful after a capture.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= adc_if.in_data;
        end
    end

    // Registered read; a same-edge write to rd_idx is seen on the next read.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data_o   = rd_data_q;
    assign state_o     = state_q;
    assign done_o      = done_q;
    assign trig_addr_o = trig_addr_q;

endmodule

// File: tb/tb_adc_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_adc_trace_buffer
// Drives captures with directed and random beat streams. The reference model
// keeps the whole beat stream since arm: the trigger is the first beat at or
// after index pretrig that satisfies the mode, and logical word k of the
// finished capture is beat (trigger - pretrig + k). Readback expectations go
// into a queue that a separate monitor drains against rd_data.
// ---------------------------------------------------------------------------
module tb_adc_trace_buffer;
    localparam int N_TI   = 8;
    localparam int N_ADC  = 8;
    localparam int N_ADDR = 4;
    localparam int DEPTH  = 2**N_ADDR;
    localparam int W      = N_TI*N_ADC;

    typedef logic [W-1:0] word_t;

    logic                     clk = 1'b0;
    logic                     rstb;
    logic                     arm;
    logic                     abort_r;
    logic [1:0]               trig_mode;
    logic signed [N_ADC-1:0]  thresh;
    logic [N_ADDR-1:0]        pretrig;
    logic [N_ADDR-1:0]        rd_addr;
    word_t                    rd_data;
    logic [2:0]               state;
    logic                     done;
    logic [N_ADDR-1:0]        trig_addr;

    adc_trace_buffer_if #(.N_TI(N_TI), .N_ADC(N_ADC)) adc_if ();

    adc_trace_buffer #(.N_TI(N_TI), .N_ADC(N_ADC), .N_ADDR(N_ADDR)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .adc_if      (adc_if.slave),
        .arm_i       (arm),
        .abort_i     (abort_r),
        .trig_mode_i (trig_mode),
        .thresh_i    (thresh),
        .pretrig_i   (pretrig),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .state_o     (state),
        .done_o      (done),
        .trig_addr_o (trig_addr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state: beat stream of the current capture and its result.
    word_t beats[$];
    bit    exts[$];
    int    last_ti;
    int    last_pre;

    // Scoreboard for readback.
    word_t exp_q[$];
    string name_q[$];
    logic  rd_req = 1'b0;
    logic  rd_req_d = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        if (rd_req_d) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got %h, expected no read", rd_data);
            end else begin
                check(name_q.pop_front(), rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic word_t rand_word();
        return {$urandom, $urandom};
    endfunction

    function automatic word_t set_lane(input word_t w, input int l, input int v);
        word_t r;
        logic [7:0] b;
        r = w;
        b = 8'(v);
        r[l*N_ADC +: N_ADC] = b;
        return r;
    endfunction

    // Trigger condition straight from the mode definitions.
    function automatic bit is_hit(input word_t w, input bit e, input int mode, input int th);
        logic [7:0] b;
        case (mode)
            1: return e;
            2: begin
                for (int l = 0; l < N_TI; l++) begin
                    b = w[l*N_ADC +: N_ADC];
                    if (int'($signed(b)) > th) return 1'b1;
                end
                return 1'b0;
            end
            default: return 1'b1;
        endcase
    endfunction

    function automatic int find_trig(input int pre, input int mode, input int th);
        for (int i = pre; i < beats.size(); i++) begin
            if (is_hit(beats[i], exts[i], mode, th)) return i;
        end
        return -1;
    endfunction

    // Arm, stream the model's beats, and check the done timing and results.
    task automatic drive_capture(input int pre, input int mode, input int th, input bit gapped);
        int ti;
        int post_len;
        int total;
        post_len = DEPTH - 1 - pre;
        ti = find_trig(pre, mode, th);
        if (ti < 0) begin
            tests++;
            fails++;
            $display("FAIL stim_no_trigger: got none, expected a trigger beat");
            return;
        end
        total = ti + 1 + post_len;
        while (beats.size() < total) begin
            beats.push_back(rand_word());
            exts.push_back(1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        adc_if.in_valid = 1'b0;
        trig_mode = 2'(mode);
        thresh    = 8'(th);
        pretrig   = N_ADDR'(pre);
        arm       = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("arm_state", state, (pre != 0) ? 1 : 2);
        check("arm_done", done, 0);

        for (int b = 0; b < total; b++) begin
            if (gapped) begin
                repeat (2) begin
                    adc_if.in_valid = 1'b0;
                    adc_if.in_data  = {N_TI{8'h7F}};
                    adc_if.ext_trig = 1'b1;
                    @(negedge clk);
                end
            end
            adc_if.in_valid = 1'b1;
            adc_if.in_data  = beats[b];
            adc_if.ext_trig = exts[b];
            if (b == total - 1) check("done_before_last", done, 0);
            @(negedge clk);
        end
        adc_if.in_valid = 1'b0;
        adc_if.ext_trig = 1'b0;
        check("done_after_last", done, 1);
        check("state_done", state, 4);
        check("trig_addr", trig_addr, ti % DEPTH);
        last_ti  = ti;
        last_pre = pre;
    endtask

    task automatic readback();
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr = N_ADDR'(k);
            rd_req  = 1'b1;
            exp_q.push_back(beats[last_ti - last_pre + k]);
            name_q.push_back($sformatf("rd[%0d]", k));
            @(negedge clk);
        end
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Start an immediate-mode capture and stop streaming partway into POST.
    task automatic start_partial(input int pre, input int nbeats);
        @(negedge clk);
        trig_mode = 2'd0;
        pretrig   = N_ADDR'(pre);
        arm       = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            adc_if.in_valid = 1'b1;
            adc_if.in_data  = rand_word();
            @(negedge clk);
        end
        adc_if.in_valid = 1'b0;
    endtask

    task automatic random_beats(input int pre, input int th);
        int n;
        word_t w;
        beats.delete();
        exts.delete();
        n = pre + int'($urandom_range(0, 5));
        for (int i = 0; i < n; i++) begin
            beats.push_back(rand_word());
            exts.push_back($urandom_range(0, 5) == 0);
        end
        w = set_lane(rand_word(), 0, 127);
        beats.push_back(w);
        exts.push_back(1'b1);
        if (th > 126) $display("note: threshold too high for forced hit");
    endtask

    initial begin
        rstb = 1'b0;
        arm = 1'b0;
        abort_r = 1'b0;
        trig_mode = 2'd0;
        thresh = '0;
        pretrig = '0;
        rd_addr = '0;
        adc_if.in_valid = 1'b0;
        adc_if.in_data  = '0;
        adc_if.ext_trig = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", state, 0);
        check("reset_done", done, 0);
        check("reset_trig_addr", trig_addr, 0);
        check("reset_rd_data", rd_data, 0);
        rstb = 1'b1;

        // Immediate capture, lane0 counts 0..15.
        beats.delete(); exts.delete();
        for (int i = 0; i < 16; i++) begin
            beats.push_back(set_lane(rand_word(), 0, i));
            exts.push_back(1'b0);
        end
        drive_capture(0, 0, 0, 1'b0);
        readback();

        // Pre-trigger wrap: ext_trig on value 40 (an ext_trig inside FILL is ignored).
        beats.delete(); exts.delete();
        for (int i = 0; i <= 50; i++) begin
            beats.push_back(set_lane(rand_word(), 0, i));
            exts.push_back(i == 40 || i == 2);
        end
        drive_capture(5, 1, 0, 1'b0);
        readback();

        // Level mode: lane7 steps 99,100,101 with all other lanes at -128.
        beats.delete(); exts.delete();
        begin
            int l7[5] = '{120, 120, 99, 100, 101};
            for (int i = 0; i < 5; i++) begin
                word_t w;
                w = {N_TI{8'h80}};
                beats.push_back(set_lane(w, 7, l7[i]));
                exts.push_back(1'b1);
            end
        end
        drive_capture(2, 2, 100, 1'b0);
        check("level_trig_beat", last_ti, 4);
        readback();

        // Gapped valid, 1 beat in 3 cycles.
        random_beats(7, 0);
        drive_capture(7, 1, 0, 1'b1);
        readback();

        // Reset for two cycles in the middle of POST.
        start_partial(3, 6);
        check("partial_in_post", state, 3);
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        check("midpost_reset_state", state, 0);
        check("midpost_reset_done", done, 0);
        check("midpost_reset_trig_addr", trig_addr, 0);
        check("midpost_reset_rd_data", rd_data, 0);
        rstb = 1'b1;

        // Arm during POST restarts with wr_ptr back at 0.
        start_partial(2, 6);
        random_beats(9, 20);
        drive_capture(9, 2, 20, 1'b0);
        readback();

        // abort+arm together -> IDLE, then beats in IDLE leave the buffer alone.
        @(negedge clk);
        abort_r = 1'b1;
        arm     = 1'b1;
        pretrig = N_ADDR'(3);
        @(negedge clk);
        abort_r = 1'b0;
        arm     = 1'b0;
        check("abort_arm_state", state, 0);
        check("abort_arm_done", done, 0);
        for (int i = 0; i < 5; i++) begin
            adc_if.in_valid = 1'b1;
            adc_if.in_data  = rand_word();
            @(negedge clk);
        end
        adc_if.in_valid = 1'b0;
        pretrig = N_ADDR'(last_pre);
        readback();

        // pretrig = DEPTH-1: DONE right after the trigger beat.
        random_beats(DEPTH - 1, 0);
        drive_capture(DEPTH - 1, 0, 0, 1'b0);
        readback();

        // Random captures.
        for (int r = 0; r < 6; r++) begin
            int pre;
            int mode;
            int th;
            pre  = int'($urandom_range(0, DEPTH - 1));
            mode = int'($urandom_range(0, 3));
            th   = int'($urandom_range(0, 120)) - 20;
            random_beats(pre, th);
            drive_capture(pre, mode, th, 1'($urandom_range(0, 1)));
            readback();
        end

        check("rd_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
